aes_job_sched: RTL and testbench
================================

Name: aes_job_sched

Overview:
- Shares one AES-128 encryption core between NUM_REQ requesters.
- Round-robin arbitrates incoming jobs and latches plaintext and key.
- Drives the core's level-sensitive start input with a clean high/low pulse, waits for the core's done pulse (with timeout), and returns a tagged result on a valid/ready response port.
- Sits between the bus-side request queues and the AES core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, response tag width; must equal max(1, clog2(NUM_REQ)).
- START_CYCLES, 3, cycles core_start is held high per job (≥3, to cover the core's input synchroniser).
- TIMEOUT, 64, max WAIT cycles before the job is aborted with an error (≥16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_data  in  NUM_REQ*128  plaintext; requester i occupies bits [i*128 +: 128]
- req_key  in  NUM_REQ*128  key, same packing as req_data
- core_start  out  1  start level to the AES core
- core_data  out  128  plaintext to the core
- core_key  out  128  key to the core
- core_done  in  1  one-cycle pulse when core_result is valid
- core_result  in  128  ciphertext from the core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_data  out  128  ciphertext; all zeros when rsp_err=1
- rsp_err  out  1  job timed out
- busy  out  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Every register is cleared on a rst=1 clock edge.
- Reset values: state=IDLE; rr_ptr=NUM_REQ-1; core_start=0; core_data=0; core_key=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; req_ready=0; busy=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Grant is combinational over req_valid, with highest priority at (rr_ptr+1) mod NUM_REQ, wrapping.
  - req_ready[g]=1 only for the granted index g, and only in IDLE.
  - On handshake (req_valid[g] & req_ready[g]): latch req_data/req_key slice g into core_data/core_key; set job_id=g; set rr_ptr=g; go to START.
- START:
  - core_start=1 for exactly START_CYCLES cycles (counter), then go to WAIT with core_start=0.
- WAIT:
  - core_start=0.
  - On core_done=1: capture core_result into rsp_data; rsp_id=job_id; rsp_err=0; go to RESP.
  - If the wait counter reaches TIMEOUT with no core_done: rsp_data=0; rsp_err=1; rsp_id=job_id; go to RESP.
  - core_done and timeout in the same cycle: core_done wins, rsp_err=0.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid falls next cycle; go to IDLE.
- core_data/core_key are held constant from START entry until the next accept, so the core may sample them at any point during the job.
- core_done outside WAIT (including a late done after a timeout) is ignored.
- Back-to-back jobs: minimum spacing between core_start rising edges is START_CYCLES + 1 (WAIT) + 1 (RESP) + 1 (IDLE). This guarantees a low phase at least 3 cycles long, so the core's edge detector re-arms.
- Latency:
  - Accept to core_start rise: 1 cycle.
  - core_done to rsp_valid: 1 cycle.
- rst during any state: abort the job, drop core_start and rsp_valid on the same edge, discard any pending response.
- busy=1 in START, WAIT and RESP.

Decomposition:
- Package aes_sched_pkg holds:
  - state enum (IDLE, START, WAIT, RESP);
  - AES_BLK_W=128;
  - counter width derivation for START_CYCLES and TIMEOUT.
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: req vector, ptr, enable;
  - output: one-hot grant plus encoded index;
  - purely combinational; the pointer register lives in aes_job_sched.

Test Plan:
- Single job: req_valid[0]=1 with data=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f; core model returns 69c4e0d86a7b0430d8cdb78070b4c55a → core_start high exactly 3 cycles, then rsp_valid=1, rsp_id=0, rsp_err=0, rsp_data equal to that ciphertext.
- Fairness: all 4 req_valid held high for 8 jobs → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order; req_ready never has more than one bit set.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_* held stable, no new req_ready, busy=1; rsp_ready=1 → IDLE the next cycle.
- Timeout: core never pulses done → exactly 64 WAIT cycles, then rsp_err=1, rsp_data=0; a done pulse arriving 5 cycles later is ignored.
- Simultaneous done and timeout on cycle 64 → rsp_err=0, rsp_data=core_result.
- Reset in WAIT: rst=1 for 1 cycle → next cycle core_start=0, rsp_valid=0, busy=0, rr_ptr=3; the next job with req_valid=4'b1111 grants requester 0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler: FSM state encoding,
// block width and the helpers used to size the phase counter.
package aes_sched_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RESP
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The counter only ever reaches max_count-1, so clog2(max_count) bits suffice.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/aes_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps,
// so the previous winner has the lowest priority.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one AES-128 core between NUM_REQ requesters: arbitrates, pulses the
// core's start level, waits for done (or times out) and returns a tagged result.
module aes_job_sched
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int START_CYCLES = 3,
   parameter int TIMEOUT      = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*AES_BLK_W-1:0]  req_data,
   input  logic [NUM_REQ*AES_BLK_W-1:0]  req_key,
   output logic                          core_start,
   output logic [AES_BLK_W-1:0]          core_data,
   output logic [AES_BLK_W-1:0]          core_key,
   input  logic                          core_done,
   input  logic [AES_BLK_W-1:0]          core_result,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [AES_BLK_W-1:0]          rsp_data,
   output logic                          rsp_err,
   output logic                          busy
);

   localparam int CNT_W = cnt_width(max_int(START_CYCLES, TIMEOUT));

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [ID_W-1:0]      rr_ptr, rr_next;
   logic [ID_W-1:0]      job_id, job_next;
   logic                 start_next;
   logic [AES_BLK_W-1:0] data_next, key_next;
   logic                 valid_next;
   logic [ID_W-1:0]      id_next;
   logic [AES_BLK_W-1:0] rdata_next;
   logic                 err_next;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_idx;

   // Grants are only offered in IDLE and never while reset is being applied.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .enable    ((state == IDLE) && !rst),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign busy      = (state != IDLE);

   // One shared counter times both the start pulse and the done timeout.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rr_next    = rr_ptr;
      job_next   = job_id;
      start_next = core_start;
      data_next  = core_data;
      key_next   = core_key;
      valid_next = rsp_valid;
      id_next    = rsp_id;
      rdata_next = rsp_data;
      err_next   = rsp_err;
      unique case (state)
         IDLE: begin
            if (|(req_valid & grant)) begin
               data_next  = req_data[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
               key_next   = req_key[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
               job_next   = grant_idx;
               rr_next    = grant_idx;
               start_next = 1'b1;
               cnt_next   = '0;
               state_next = START;
            end
         end
         START: begin
            if (cnt == CNT_W'(START_CYCLES - 1)) begin
               start_next = 1'b0;
               cnt_next   = '0;
               state_next = WAIT;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         WAIT: begin
            // A done pulse on the final timeout cycle still counts as success.
            if (core_done) begin
               rdata_next = core_result;
               err_next   = 1'b0;
               id_next    = job_id;
               valid_next = 1'b1;
               state_next = RESP;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               rdata_next = '0;
               err_next   = 1'b1;
               id_next    = job_id;
               valid_next = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         job_id     <= '0;
         core_start <= 1'b0;
         core_data  <= '0;
         core_key   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         rr_ptr     <= rr_next;
         job_id     <= job_next;
         core_start <= start_next;
         core_data  <= data_next;
         core_key   <= key_next;
         rsp_valid  <= valid_next;
         rsp_id     <= id_next;
         rsp_data   <= rdata_next;
         rsp_err    <= err_next;
      end
   end

endmodule

// File: tb/tb_aes_job_sched.sv
// Randomized scoreboard bench for aes_job_sched with a behavioural AES core stand-in
// and a round-robin reference model.
module tb_aes_job_sched;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int SC  = 3;
   localparam int TO  = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*128-1:0]   req_data;
   logic [N*128-1:0]   req_key;
   logic               core_start;
   logic [127:0]       core_data;
   logic [127:0]       core_key;
   logic               core_done;
   logic [127:0]       core_result;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [127:0]       rsp_data;
   logic               rsp_err;
   logic               busy;

   logic [127:0]       pt [N];
   logic [127:0]       ky [N];

   typedef struct {
      logic [IDW-1:0] id;
      logic [127:0]   data;
      logic           err;
   } rsp_t;

   typedef struct {
      logic [127:0] data;
      logic [127:0] key;
      int           delay;
   } core_job_t;

   rsp_t      rsp_q[$];
   core_job_t core_q[$];

   int errors = 0;
   int checks = 0;
   int last_g = N - 1;
   int rdy_mode = 1;

   aes_job_sched #(
      .NUM_REQ      (N),
      .ID_W         (IDW),
      .START_CYCLES (SC),
      .TIMEOUT      (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .req_key     (req_key),
      .core_start  (core_start),
      .core_data   (core_data),
      .core_key    (core_key),
      .core_done   (core_done),
      .core_result (core_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      req_key  = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i*128 +: 128] = pt[i];
         req_key[i*128 +: 128]  = ky[i];
      end
   end

   // Stand-in cipher: the FIPS-197 vector is honoured, anything else gets a cheap mix.
   function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
      if (d == 128'h00112233445566778899aabbccddeeff && k == 128'h000102030405060708090a0b0c0d0e0f)
         return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
   endfunction

   function automatic int next_grant(input logic [N-1:0] v);
      for (int i = 1; i <= N; i++) begin
         if (v[(last_g + i) % N]) return (last_g + i) % N;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got timeout expected event", name);
   endtask

   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       rsp_ready = (($urandom % 4) != 0);
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'b0;
      endcase
   end

   // Core stand-in: measures the start pulse, answers after the job's delay and
   // measures the done-to-response latency.
   initial begin
      core_done   = 1'b0;
      core_result = '0;
      forever begin
         core_job_t j;
         int        n;
         int        k;
         int        lat;
         bit        seen;
         @(posedge core_start);
         if (core_q.size() == 0) begin
            failTimeout("core_job_queue");
            j = '{data: '0, key: '0, delay: 1};
         end else begin
            j = core_q.pop_front();
         end
         n = 0;
         @(negedge clk);
         while (core_start && n < 50) begin
            n++;
            checkOutput("core_data", core_data, j.data);
            checkOutput("core_key", core_key, j.key);
            @(negedge clk);
         end
         checkOutput("start_len", 128'(n), 128'(SC));
         core_result = cipher(core_data, core_key);
         lat  = (j.delay < TO) ? j.delay : TO;
         k    = 0;
         seen = 1'b0;
         while (k < 300) begin
            if (rst) break;
            core_done = (k == j.delay - 1);
            if (rsp_valid && !seen) begin
               seen = 1'b1;
               checkOutput("wait_len", 128'(k), 128'(lat));
            end
            if (seen && k >= j.delay) break;
            @(negedge clk);
            k++;
         end
         core_done = 1'b0;
         if (!rst && !seen) failTimeout("rsp_valid");
         if (!rst && j.delay > TO) checkOutput("late_done_ignored", 128'({rsp_valid, busy}), 128'(0));
      end
   end

   logic           held = 1'b0;
   logic [IDW-1:0] p_id;
   logic [127:0]   p_data;
   logic           p_err;
   rsp_t           e;

   // Response monitor: stability under backpressure, then scoreboard pop on handshake.
   always @(negedge clk) begin
      if (rst || !rsp_valid) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checkOutput("rsp_hold_id", 128'(rsp_id), 128'(p_id));
            checkOutput("rsp_hold_data", rsp_data, p_data);
            checkOutput("rsp_hold_err", 128'(rsp_err), 128'(p_err));
         end
         if (rsp_ready) begin
            if (rsp_q.size() == 0) begin
               failTimeout("unexpected_rsp");
            end else begin
               e = rsp_q.pop_front();
               checkOutput("rsp_id", 128'(rsp_id), 128'(e.id));
               checkOutput("rsp_data", rsp_data, e.data);
               checkOutput("rsp_err", 128'(rsp_err), 128'(e.err));
            end
            held = 1'b0;
         end else begin
            held   = 1'b1;
            p_id   = rsp_id;
            p_data = rsp_data;
            p_err  = rsp_err;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("req_ready_onehot", 128'($countones(req_ready) <= 1), 128'(1));
         checkOutput("ready_only_idle", 128'(busy && (|req_ready)), 128'(0));
      end
   end

   task automatic resetDut();
      rst       = 1'b1;
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 128'(req_ready), 128'(0));
      checkOutput("rst_core_start", 128'(core_start), 128'(0));
      checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_rsp_id", 128'(rsp_id), 128'(0));
      checkOutput("rst_rsp_data", rsp_data, 128'(0));
      checkOutput("rst_rsp_err", 128'(rsp_err), 128'(0));
      checkOutput("rst_core_data", core_data, 128'(0));
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = '0;
      last_g    = N - 1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] pattern, input int delay, input bit drop,
                                input bit expect_rsp, input bit rand_data);
      int           g;
      int           n;
      logic [N-1:0] onehot;
      logic [127:0] exp_data;
      @(posedge clk);
      #1;
      if (rand_data) begin
         for (int i = 0; i < N; i++) begin
            pt[i] = {$urandom, $urandom, $urandom, $urandom};
            ky[i] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      req_valid = pattern;
      g         = next_grant(pattern);
      last_g    = g;
      onehot    = '0;
      onehot[g] = 1'b1;
      core_q.push_back('{data: pt[g], key: ky[g], delay: delay});
      exp_data = (delay > TO) ? 128'(0) : cipher(pt[g], ky[g]);
      if (expect_rsp) rsp_q.push_back('{id: IDW'(g), data: exp_data, err: (delay > TO)});
      n = 0;
      @(negedge clk);
      while (!(|(req_valid & req_ready)) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) failTimeout("accept");
      else checkOutput("grant", 128'(req_ready), 128'(onehot));
      @(posedge clk);
      #1;
      if (drop) req_valid = '0;
   endtask

   task automatic waitDrain();
      int n;
      req_valid = '0;
      n = 0;
      while ((rsp_q.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) failTimeout("drain");
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         pt[i] = '0;
         ky[i] = '0;
      end
      resetDut();

      // Known-answer single job on requester 0.
      pt[0] = 128'h00112233445566778899aabbccddeeff;
      ky[0] = 128'h000102030405060708090a0b0c0d0e0f;
      applyStimulus(4'b0001, 5, 1'b1, 1'b1, 1'b0);
      waitDrain();

      // Fairness with all requesters active from a fresh pointer.
      resetDut();
      for (int j = 0; j < 8; j++) applyStimulus(4'b1111, 1 + int'($urandom % 20), 1'b0, 1'b1, 1'b1);
      waitDrain();

      // Backpressure: response must hold for 10 stalled cycles.
      rdy_mode = 2;
      applyStimulus(4'b1111, 4, 1'b0, 1'b1, 1'b1);
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) failTimeout("bp_rsp_valid");
      repeat (10) begin
         checkOutput("bp_busy", 128'(busy), 128'(1));
         checkOutput("bp_req_ready", 128'(req_ready), 128'(0));
         checkOutput("bp_rsp_valid", 128'(rsp_valid), 128'(1));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rdy_mode  = 1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp_idle_busy", 128'(busy), 128'(0));
      checkOutput("bp_idle_valid", 128'(rsp_valid), 128'(0));
      waitDrain();

      // Timeout with a late done, then done on the final timeout cycle.
      applyStimulus(4'b0100, TO + 5, 1'b1, 1'b1, 1'b1);
      waitDrain();
      repeat (10) @(posedge clk);
      applyStimulus(4'b0010, TO, 1'b1, 1'b1, 1'b1);
      waitDrain();

      // Random patterns, latencies and response backpressure.
      rdy_mode = 0;
      for (int j = 0; j < 20; j++) begin
         applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(1, 40)),
                       1'($urandom % 2), 1'b1, 1'b1);
      end
      waitDrain();

      // Reset in WAIT aborts the job and restarts arbitration at requester 0.
      rdy_mode = 1;
      applyStimulus(4'b1111, 1000, 1'b1, 1'b0, 1'b1);
      repeat (SC + 6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstw_core_start", 128'(core_start), 128'(0));
      checkOutput("rstw_rsp_valid", 128'(rsp_valid), 128'(0));
      checkOutput("rstw_busy", 128'(busy), 128'(0));
      last_g = N - 1;
      applyStimulus(4'b1111, 7, 1'b1, 1'b1, 1'b1);
      waitDrain();
      repeat (5) @(posedge clk);
      checkOutput("core_q_empty", 128'(core_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
